// File: rtl/sa_tile_engine.sv
// sa_tile_engine: tiled signed matrix-multiply engine with an output-stationary
// N x N MAC array, operand skew, requantization and a backpressured row writer.
// Optional build macro: SA_TILE_ROUND_EN (round-half-up requantization; floor otherwise).
module sa_tile_engine #(
    parameter int N      = 8,
    parameter int DW     = 8,
    parameter int AW     = 24,
    parameter int ADDR_W = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          a_tiles,
    input  logic [7:0]          b_tiles,
    input  logic [7:0]          k_len,
    input  logic [4:0]          out_shift,
    output logic                busy,
    output logic                done,
    output logic                ren_n,
    output logic [ADDR_W-1:0]   raddr_a,
    output logic [ADDR_W-1:0]   raddr_b,
    input  logic [N*DW-1:0]     rdata_a,
    input  logic [N*DW-1:0]     rdata_b,
    output logic                wen_n,
    input  logic                wready,
    output logic [ADDR_W-1:0]   waddr,
    output logic [N*DW-1:0]     wdata
);

    localparam int CW = $clog2(2 * N);
    localparam logic signed [AW:0] QMAX = (AW+1)'(2**(DW-1) - 1);
    localparam logic signed [AW:0] QMIN = (AW+1)'(-(2**(DW-1)));

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

    state_t          state;
    logic [7:0]      cfg_at, cfg_bt, cfg_kl, ra, cb, k_cnt;
    logic [4:0]      cfg_sh;
    logic [CW-1:0]   f_cnt, row, row_sel;
    logic            rd_vld, clr, last_cb, last_ra;
    logic [7:0]      nxt_ra, nxt_cb;
    logic [ADDR_W-1:0] nxt_raddr_a, nxt_raddr_b, wbase;
    logic [N*DW-1:0] q_row;

    logic signed [DW-1:0] a_feed [N];
    logic signed [DW-1:0] b_feed [N];
    logic signed [DW-1:0] a_w [N][N];
    logic signed [DW-1:0] b_w [N][N];
    logic signed [AW-1:0] acc_w [N][N];

    function automatic logic [DW-1:0] quant(input logic signed [AW-1:0] x, input logic [4:0] sh);
        logic signed [AW:0] t;
        t = {x[AW-1], x};
`ifdef SA_TILE_ROUND_EN
        if (sh != 5'd0) t = t + ((AW+1)'(1) << (sh - 5'd1));
`endif
        t = t >>> sh;
        if (t > QMAX)      quant = DW'(QMAX);
        else if (t < QMIN) quant = DW'(QMIN);
        else               quant = t[DW-1:0];
    endfunction

    assign last_cb     = (cb == cfg_bt - 8'd1);
    assign last_ra     = (ra == cfg_at - 8'd1);
    assign nxt_ra      = last_cb ? ra + 8'd1 : ra;
    assign nxt_cb      = last_cb ? 8'd0 : cb + 8'd1;
    assign nxt_raddr_a = ADDR_W'(32'(nxt_ra) * 32'(cfg_kl));
    assign nxt_raddr_b = ADDR_W'(32'(nxt_cb) * 32'(cfg_kl));
    assign wbase       = ADDR_W'((32'(ra) * 32'(cfg_bt) + 32'(cb)) * 32'(N));
    assign clr         = (state == LOAD) && (k_cnt == 8'd0);
    assign row_sel     = (state == DRAIN) ? row + CW'(1) : '0;

    // Read data is valid one cycle after a read was issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_vld <= 1'b0;
        else        rd_vld <= ~ren_n;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [DW-1:0] a_raw, b_raw;
        assign a_raw = rd_vld ? rdata_a[i*DW +: DW] : '0;
        assign b_raw = rd_vld ? rdata_b[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_feed[i] = a_raw;
            assign b_feed[i] = b_raw;
        end else begin : g_skew
            logic signed [DW-1:0] a_sr [i];
            logic signed [DW-1:0] b_sr [i];
            // Lane i is delayed by i stages so operands meet on the diagonal wavefront
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned s = 0; s < i; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_raw;
                    b_sr[0] <= b_raw;
                    for (int unsigned s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end
            assign a_feed[i] = a_sr[i-1];
            assign b_feed[i] = b_sr[i-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DW-1:0]   a_in, b_in, a_q, b_q;
            logic signed [2*DW-1:0] prod;
            logic signed [AW-1:0]   acc_q;
            if (gj == 0) begin : g_a_edge
                assign a_in = a_feed[gi];
            end else begin : g_a_inner
                assign a_in = a_w[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in = b_feed[gj];
            end else begin : g_b_inner
                assign b_in = b_w[gi-1][gj];
            end
            assign prod = a_in * b_in;
            // PE: pass a right and b down, accumulate product modulo 2^AW
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= clr ? '0 : acc_q + AW'(prod);
                end
            end
            assign a_w[gi][gj]   = a_q;
            assign b_w[gi][gj]   = b_q;
            assign acc_w[gi][gj] = acc_q;
        end
    end

    // Requantized row that the writer will present next
    always_comb begin
        q_row = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (row_sel == CW'(i)) begin
                for (int unsigned j = 0; j < N; j++) q_row[j*DW +: DW] = quant(acc_w[i][j], cfg_sh);
            end
        end
    end

    // Job sequencer: tile loops, read issue, flush wait and backpressured row drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cfg_at <= '0; cfg_bt <= '0; cfg_kl <= '0; cfg_sh <= '0;
            ra <= '0; cb <= '0; k_cnt <= '0; f_cnt <= '0; row <= '0;
            busy <= 1'b0; done <= 1'b0; ren_n <= 1'b1; wen_n <= 1'b1;
            raddr_a <= '0; raddr_b <= '0; waddr <= '0; wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (a_tiles != 8'd0 && b_tiles != 8'd0 && k_len != 8'd0) begin
                        cfg_at <= a_tiles; cfg_bt <= b_tiles; cfg_kl <= k_len; cfg_sh <= out_shift;
                        ra <= '0; cb <= '0; k_cnt <= '0;
                        raddr_a <= '0; raddr_b <= '0;
                        ren_n <= 1'b0; busy <= 1'b1;
                        state <= LOAD;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                LOAD: if (k_cnt == cfg_kl - 8'd1) begin
                    ren_n <= 1'b1;
                    f_cnt <= '0;
                    state <= FLUSH;
                end else begin
                    k_cnt   <= k_cnt + 8'd1;
                    raddr_a <= raddr_a + ADDR_W'(1);
                    raddr_b <= raddr_b + ADDR_W'(1);
                end
                FLUSH: if (f_cnt == CW'(2*N - 1)) begin
                    wen_n <= 1'b0;
                    waddr <= wbase;
                    wdata <= q_row;
                    row   <= '0;
                    state <= DRAIN;
                end else begin
                    f_cnt <= f_cnt + CW'(1);
                end
                DRAIN: if (wready) begin
                    if (row == CW'(N - 1)) begin
                        wen_n <= 1'b1;
                        if (last_cb && last_ra) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ra <= nxt_ra; cb <= nxt_cb; k_cnt <= '0;
                            raddr_a <= nxt_raddr_a; raddr_b <= nxt_raddr_b;
                            ren_n <= 1'b0;
                            state <= LOAD;
                        end
                    end else begin
                        row   <= row + CW'(1);
                        waddr <= waddr + ADDR_W'(1);
                        wdata <= q_row;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_tile_engine.sv
// Self-checking bench for sa_tile_engine (N=4): operand SRAM models, a
// plain-arithmetic matrix-multiply reference model and an output monitor.
module tb_sa_tile_engine;

    localparam int N = 4, DW = 8, AW = 24, ADDR_W = 13;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wready = 1'b1;
    logic [7:0] a_tiles = '0, b_tiles = '0, k_len = '0;
    logic [4:0] out_shift = '0;
    logic busy, done, ren_n, wen_n;
    logic [ADDR_W-1:0] raddr_a, raddr_b, waddr;
    logic [N*DW-1:0] rdata_a, rdata_b, wdata;

    sa_tile_engine #(.N(N), .DW(DW), .AW(AW), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_tiles(a_tiles), .b_tiles(b_tiles), .k_len(k_len), .out_shift(out_shift),
        .busy(busy), .done(done), .ren_n(ren_n),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .wen_n(wen_n), .wready(wready), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Operand SRAMs, one-cycle read latency; idle cycles return garbage
    logic [N*DW-1:0] mem_a [256];
    logic [N*DW-1:0] mem_b [256];
    always @(posedge clk) begin
        if (!ren_n) begin
            rdata_a <= mem_a[raddr_a[7:0]];
            rdata_b <= mem_b[raddr_b[7:0]];
        end else begin
            rdata_a <= $urandom;
            rdata_b <= $urandom;
        end
    end

    logic [2*ADDR_W-1:0]      exp_rd [$];
    logic [ADDR_W+N*DW-1:0]   exp_wr [$];

    bit mon_en = 0, seen_ren = 0, prev_stall = 0;
    int unsigned done_cnt = 0, done_total = 0, done_cyc = 0, last_wr_cyc = 0, first_ren_cyc = 0;
    logic [ADDR_W-1:0] prev_waddr;
    logic [N*DW-1:0]   prev_wdata;
    logic [2*ADDR_W-1:0]    rd_e;
    logic [ADDR_W+N*DW-1:0] wr_e;

    always @(negedge clk) if (done) done_total++;

    // Output monitor: read/write order, stall hold, done timing
    always @(negedge clk) begin
        if (mon_en) begin
            if (!ren_n) begin
                if (!seen_ren) begin seen_ren = 1; first_ren_cyc = cyc; end
                if (exp_rd.size() == 0) check("rd_extra", 64'(ren_n), 1);
                else begin
                    rd_e = exp_rd.pop_front();
                    check("raddr_a", raddr_a, rd_e[2*ADDR_W-1:ADDR_W]);
                    check("raddr_b", raddr_b, rd_e[ADDR_W-1:0]);
                end
            end
            if (prev_stall) begin
                check("hold_waddr", waddr, prev_waddr);
                check("hold_wdata", wdata, prev_wdata);
            end
            if (!wen_n && wready) begin
                if (exp_wr.size() == 0) check("wr_extra", 64'(wen_n), 1);
                else begin
                    wr_e = exp_wr.pop_front();
                    check("waddr", waddr, wr_e[ADDR_W+N*DW-1:N*DW]);
                    check("wdata", wdata, wr_e[N*DW-1:0]);
                end
                last_wr_cyc = cyc;
            end
            prev_stall = !wen_n && !wready;
            prev_waddr = waddr;
            prev_wdata = wdata;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
        end
    end

    function automatic logic [DW-1:0] model_q(input longint s_in, input int sh);
        longint s;
        s = (s_in <<< (64 - AW)) >>> (64 - AW);
`ifdef SA_TILE_ROUND_EN
        if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
`endif
        s = s >>> sh;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s[DW-1:0];
    endfunction

    task automatic build_expect(input int at, input int bt, input int kl, input int sh);
        logic [N*DW-1:0] rowv;
        longint s;
        for (int ra = 0; ra < at; ra++)
            for (int cb = 0; cb < bt; cb++)
                for (int k = 0; k < kl; k++)
                    exp_rd.push_back({ADDR_W'(ra*kl + k), ADDR_W'(cb*kl + k)});
        for (int ra = 0; ra < at; ra++)
            for (int cb = 0; cb < bt; cb++)
                for (int r = 0; r < N; r++) begin
                    rowv = '0;
                    for (int j = 0; j < N; j++) begin
                        s = 0;
                        for (int k = 0; k < kl; k++)
                            s += longint'($signed(mem_a[ra*kl + k][r*DW +: DW])) *
                                 longint'($signed(mem_b[cb*kl + k][j*DW +: DW]));
                        rowv[j*DW +: DW] = model_q(s, sh);
                    end
                    exp_wr.push_back({ADDR_W'((ra*bt + cb)*N + r), rowv});
                end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) begin
            mem_a[a] = $urandom;
            mem_b[a] = $urandom;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ren_n"}, ren_n, 1);
        check({tag, "_wen_n"}, wen_n, 1);
        check({tag, "_raddr_a"}, raddr_a, 0);
        check({tag, "_raddr_b"}, raddr_b, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
    endtask

    task automatic run_job(input int at, input int bt, input int kl, input int sh,
                           input bit stall, input bit pester);
        int unsigned t0;
        bit work;
        work = (at != 0) && (bt != 0) && (kl != 0);
        exp_rd.delete();
        exp_wr.delete();
        if (work) build_expect(at, bt, kl, sh);
        done_cnt = 0; seen_ren = 0; last_wr_cyc = 0; prev_stall = 0; mon_en = 1;
        @(posedge clk); #1;
        start = 1; a_tiles = 8'(at); b_tiles = 8'(bt); k_len = 8'(kl); out_shift = 5'(sh);
        wready = 1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 0;
        a_tiles = 8'($urandom); b_tiles = 8'($urandom); k_len = 8'($urandom); out_shift = 5'($urandom);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
            @(posedge clk); #1;
            wready = stall ? 1'($urandom % 2) : 1'b1;
            if (pester) begin
                start = ($urandom % 4) == 0;
                a_tiles = 8'($urandom % 3); b_tiles = 8'($urandom % 3); k_len = 8'($urandom % 3);
            end
        end
        start = 0;
        wready = 1;
        repeat (3) @(negedge clk);
        check("done_cnt", done_cnt, 1);
        if (work) begin
            check("first_load", first_ren_cyc - t0, 1);
            check("done_lat", done_cyc - last_wr_cyc, 1);
        end else begin
            check("zero_done_lat", done_cyc - t0, 1);
            check("zero_no_reads", 64'(seen_ren), 0);
        end
        check("rd_left", exp_rd.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("busy_idle", busy, 0);
        mon_en = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) rst_n = 1;

        // identity A against a counting B
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) begin
                mem_a[k][i*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
                mem_b[k][i*DW +: DW] = 8'(4*k + i + 1);
            end
        run_job(1, 1, 4, 0, 0, 0);

        // saturation and rounding with all operands at 127
        for (int k = 0; k < 8; k++) begin
            mem_a[k] = {N{8'd127}};
            mem_b[k] = {N{8'd127}};
        end
        run_job(1, 1, 8, 0, 0, 0);
        run_job(1, 1, 8, 17, 0, 0);

        // negative operands
        mem_a[0] = {N{8'h80}};
        mem_b[0] = {N{8'd127}};
        run_job(1, 1, 1, 0, 0, 0);
        run_job(1, 1, 1, 7, 0, 0);

        // multi-tile, then the same with backpressure and start pulses while busy
        fill_random();
        run_job(2, 3, 2, 9, 0, 0);
        run_job(2, 3, 2, 9, 1, 1);

        // zero-dimension starts
        run_job(1, 1, 0, 0, 0, 0);
        run_job(0, 2, 3, 0, 0, 0);

        // randomized jobs
        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_job(1 + $urandom % 2, 1 + $urandom % 3, 1 + $urandom % 6,
                    $urandom % 21, $urandom % 2, $urandom % 2);
        end

        // reset asserted in the middle of LOAD
        fill_random();
        @(posedge clk); #1;
        start = 1; a_tiles = 1; b_tiles = 1; k_len = 20; out_shift = 0;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 check("mid_in_load", ren_n, 0);
        d0 = done_total;
        #1 rst_n = 0;
        #1 check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_total - d0, 0);
        check("midrst_idle_ren", ren_n, 1);

        // recovery job after the abort
        run_job(1, 2, 3, 4, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
